// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes and SR/Cause field layout.
// Timer-related numbers are used only when CP0_TIMER_EN is defined.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int SR_IM_HI    = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc;
  } cause_t;

  function automatic logic [31:0] pack_sr(input sr_t s);
    logic [31:0] v;
    v = 32'h0000_0000;
    v[SR_IM_HI:SR_IM_LO] = s.im;
    v[SR_EXL]            = s.exl;
    v[SR_IE]             = s.ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input cause_t c);
    logic [31:0] v;
    v = 32'h0000_0000;
    v[CAUSE_BD]                     = c.bd;
    v[CAUSE_IP_HI:CAUSE_IP_LO]      = c.ip;
    v[CAUSE_EXC_HI:CAUSE_EXC_LO]    = c.exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count free-runs, timer interrupt latches on a nonzero match
// and is cleared by any Compare write.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we_count,
  input  logic        i_we_compare,
  input  logic [31:0] i_din,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_irq
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_irq;

  // Count/Compare/irq state; a Compare write beats a simultaneous match
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count   <= 32'h0000_0000;
      r_compare <= 32'h0000_0000;
      r_irq     <= 1'b0;
    end else begin
      if (i_we_count) r_count <= i_din;
      else            r_count <= r_count + 32'h0000_0001;

      if (i_we_compare) begin
        r_compare <= i_din;
        r_irq     <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'h0000_0000)) begin
        r_compare <= r_compare;
        r_irq     <= 1'b1;
      end else begin
        r_compare <= r_compare;
        r_irq     <= r_irq;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_irq     = r_irq;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC/PRId, exception/interrupt flush request, eret.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h2023_1110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        req,
  output logic [31:0] handler_pc
);

  sr_t         r_sr;
  cause_t      r_cause;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_en;
  logic        w_timer_irq;

  assign w_int_req = (|(r_cause.ip & r_sr.im)) & r_sr.ie & ~r_sr.exl;
  assign w_exc_req = exc_valid & ~r_sr.exl;
  assign w_req     = w_int_req | w_exc_req;
  // A flushed instruction must not commit its mtc0
  assign w_wr_en   = we & ~w_req;

`ifdef CP0_TIMER_EN
  logic [31:0] w_count;
  logic [31:0] w_compare;

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_we_count   (w_wr_en && (addr == REG_COUNT)),
    .i_we_compare (w_wr_en && (addr == REG_COMPARE)),
    .i_din        (din),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_irq        (w_timer_irq)
  );
`else
  assign w_timer_irq = 1'b0;
`endif

  // SR/Cause/EPC update: flush entry, then mtc0, then eret clearing EXL
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr    <= '0;
      r_cause <= '0;
      r_epc   <= 32'h0000_0000;
    end else begin
      r_cause.ip <= {hw_int[5] | w_timer_irq, hw_int[4:0]};
      if (w_req) begin
        r_sr.exl    <= 1'b1;
        r_cause.exc <= w_int_req ? EXC_INT : exc_code;
        r_cause.bd  <= bd_in;
        r_epc       <= bd_in ? (vpc - 32'h0000_0004) : vpc;
      end else begin
        if (w_wr_en && (addr == REG_SR)) begin
          r_sr.im  <= din[SR_IM_HI:SR_IM_LO];
          r_sr.ie  <= din[SR_IE];
          r_sr.exl <= eret ? 1'b0 : din[SR_EXL];
        end else if (eret) begin
          r_sr.exl <= 1'b0;
        end else begin
          r_sr <= r_sr;
        end
        if (w_wr_en && (addr == REG_EPC)) r_epc <= din;
        else                              r_epc <= r_epc;
      end
    end
  end

  // mfc0 read mux
  always_comb begin
    dout = 32'h0000_0000;
    case (addr)
      REG_SR:      dout = pack_sr(r_sr);
      REG_CAUSE:   dout = pack_cause(r_cause);
      REG_EPC:     dout = r_epc;
      REG_PRID:    dout = PRID_VALUE;
`ifdef CP0_TIMER_EN
      REG_COUNT:   dout = w_count;
      REG_COMPARE: dout = w_compare;
`endif
      default:     dout = 32'h0000_0000;
    endcase
  end

  assign req        = w_req;
  assign epc_out    = r_epc;
  assign handler_pc = HANDLER_ADDR;

endmodule
